// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one ALU between NREQ requesters. Only one transaction is in flight;
// the winner's operands are registered, alu_en pulses for one cycle and the result returns via valid/ready.
package instr_pack;
  typedef enum logic [2:0] {
    AMP  = 3'd0,
    ADD  = 3'd1,
    SUB  = 3'd2,
    ANDL = 3'd3,
    ORL  = 3'd4,
    XORL = 3'd5,
    SHL  = 3'd6,
    EQL5 = 3'd7
  } math;
endpackage

module alu_arbiter
  import instr_pack::*;
#(
  parameter int NREQ = 2,
  parameter int DW   = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req_valid,
  output logic [NREQ-1:0] req_ready,
  input  math             req_op [NREQ],
  input  logic [DW-1:0]   req_x  [NREQ],
  input  logic [DW-1:0]   req_y  [NREQ],
  input  logic [DW-1:0]   req_m  [NREQ],
  input  logic [NREQ-1:0] req_rs,
  output logic [NREQ-1:0] rsp_valid,
  input  logic [NREQ-1:0] rsp_ready,
  output logic [DW-1:0]   rsp_data,
  output logic            busy,
  output logic [DW-1:0]   alu_x,
  output logic [DW-1:0]   alu_y,
  output logic [DW-1:0]   alu_m,
  output math             alu_op,
  output logic            alu_en,
  output logic            alu_rs,
  input  logic [DW-1:0]   alu_r,
  input  logic [DW-1:0]   alu_s
);
  localparam int IW = $clog2(NREQ);
  localparam logic [IW-1:0] ONE_IDX  = IW'(1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NREQ - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   gnt_q, gnt_d;
  logic [DW-1:0]   alu_x_q, alu_x_d;
  logic [DW-1:0]   alu_y_q, alu_y_d;
  logic [DW-1:0]   alu_m_q, alu_m_d;
  math             alu_op_q, alu_op_d;
  logic            alu_rs_q, alu_rs_d;
  logic            alu_en_q, alu_en_d;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rsp_data_q, rsp_data_d;
  logic            busy_q, busy_d;

  logic            win_found_s;
  logic [IW-1:0]   win_idx_s;
  logic [IW-1:0]   cand_s;
  logic            take_s;

  function automatic logic [NREQ-1:0] idx_onehot(input logic [IW-1:0] idx);
    logic [NREQ-1:0] v;
    v      = {NREQ{1'b0}};
    v[idx] = 1'b1;
    return v;
  endfunction

  // Round-robin search: first valid port at or above ptr_q, wrapping modulo NREQ.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = {IW{1'b0}};
    cand_s      = {IW{1'b0}};
    for (int k = 0; k < NREQ; k++) begin
      cand_s = IW'((int'(ptr_q) + k) % NREQ);
      if (!win_found_s && req_valid[cand_s]) begin
        win_found_s = 1'b1;
        win_idx_s   = cand_s;
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  assign take_s    = (state_q == S_IDLE) && !reset && win_found_s;
  assign req_ready = take_s ? idx_onehot(win_idx_s) : {NREQ{1'b0}};

  // Next-state and datapath register inputs for the single in-flight transaction.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    alu_x_d     = alu_x_q;
    alu_y_d     = alu_y_q;
    alu_m_d     = alu_m_q;
    alu_op_d    = alu_op_q;
    alu_rs_d    = alu_rs_q;
    alu_en_d    = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      S_IDLE: begin
        if (take_s) begin
          state_d  = S_ISSUE;
          gnt_d    = win_idx_s;
          ptr_d    = (win_idx_s == LAST_IDX) ? {IW{1'b0}} : (win_idx_s + ONE_IDX);
          alu_x_d  = req_x[win_idx_s];
          alu_y_d  = req_y[win_idx_s];
          alu_m_d  = req_m[win_idx_s];
          alu_op_d = req_op[win_idx_s];
          alu_rs_d = req_rs[win_idx_s];
          alu_en_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        rsp_data_d  = alu_rs_q ? alu_s : alu_r;
        rsp_valid_d = idx_onehot(gnt_q);
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready[gnt_q]) begin
          rsp_valid_d = {NREQ{1'b0}};
          state_d     = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset drops any in-flight transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ptr_q       <= {IW{1'b0}};
      gnt_q       <= {IW{1'b0}};
      alu_x_q     <= {DW{1'b0}};
      alu_y_q     <= {DW{1'b0}};
      alu_m_q     <= {DW{1'b0}};
      alu_op_q    <= AMP;
      alu_rs_q    <= 1'b0;
      alu_en_q    <= 1'b0;
      rsp_valid_q <= {NREQ{1'b0}};
      rsp_data_q  <= {DW{1'b0}};
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      alu_x_q     <= alu_x_d;
      alu_y_q     <= alu_y_d;
      alu_m_q     <= alu_m_d;
      alu_op_q    <= alu_op_d;
      alu_rs_q    <= alu_rs_d;
      alu_en_q    <= alu_en_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      busy_q      <= busy_d;
    end
  end

  assign alu_x     = alu_x_q;
  assign alu_y     = alu_y_q;
  assign alu_m     = alu_m_q;
  assign alu_op    = alu_op_q;
  assign alu_rs    = alu_rs_q;
  assign alu_en    = alu_en_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = busy_q;

endmodule
